// File: rtl/uart_pkg.sv
// Shared UART constants and the arbiter state encoding.
package uart_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle shared by the arbiter and its environment.
interface uart_tx_arbiter_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]        REQ;
    logic [NREQ*DATA_W-1:0] REQ_DATA;
    logic [NREQ-1:0]        GNT;
    logic [NREQ-1:0]        DONE;
    logic                   ERR;
    logic [IDX_W-1:0]       OWNER;
    logic [DATA_W-1:0]      TX_DATA;
    logic                   TX_EN;
    logic                   TX_STATUS;

    modport master (
        input  REQ, REQ_DATA, TX_STATUS,
        output GNT, DONE, ERR, OWNER, TX_DATA, TX_EN
    );

    modport slave (
        output REQ, REQ_DATA, TX_STATUS,
        input  GNT, DONE, ERR, OWNER, TX_DATA, TX_EN
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after the last winner.
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]          req_i,
    input  logic [$clog2(NREQ)-1:0]  last_i,
    output logic                     any_req_c,
    output logic [$clog2(NREQ)-1:0]  winner_c
);
    localparam int unsigned IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] idx;

    // Scan from farthest to nearest so the nearest set bit after last wins.
    always_comb begin
        any_req_c = |req_i;
        winner_c  = '0;
        idx       = '0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            idx = IDX_W'((32'(last_i) + k) % NREQ);
            if (req_i[idx]) begin
                winner_c = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NREQ requesters,
// tracking the TX_STATUS handshake and reporting DONE or ERR to the owner.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ACK_TIMEOUT = 4,
    parameter int unsigned TIMEOUT     = 200
) (
    input  logic             baud_clk,
    input  logic             reset,
    uart_tx_arbiter_if.master bus
);
    localparam int unsigned IDX_W   = $clog2(NREQ);
    localparam int unsigned TMR_MAX = (ACK_TIMEOUT > TIMEOUT) ? ACK_TIMEOUT : TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    state_e            state_q;
    logic [TMR_W-1:0]  timer_q;
    logic [IDX_W-1:0]  last_q;
    logic [IDX_W-1:0]  owner_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic              err_q;
    logic              tx_en_q;
    logic [DATA_W-1:0] tx_data_q;

    logic              pick_any_c;
    logic [IDX_W-1:0]  pick_winner_c;
    logic [TMR_W-1:0]  timer_inc_c;
    logic [DATA_W-1:0] req_bytes [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_bytes
        assign req_bytes[g] = bus.REQ_DATA[g*DATA_W +: DATA_W];
    end

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i     (bus.REQ),
        .last_i    (last_q),
        .any_req_c (pick_any_c),
        .winner_c  (pick_winner_c)
    );

    // Saturating timer increment.
    assign timer_inc_c = (timer_q == TMR_W'(TMR_MAX)) ? timer_q : timer_q + TMR_W'(1);

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            last_q    <= IDX_W'(NREQ - 1);
            owner_q   <= IDX_W'(NREQ - 1);
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            tx_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A transmitter still shifting (e.g. from before reset) blocks grants.
                    if (pick_any_c && bus.TX_STATUS) begin
                        tx_data_q <= req_bytes[pick_winner_c];
                        gnt_q     <= NREQ'(1) << pick_winner_c;
                        tx_en_q   <= 1'b1;
                        owner_q   <= pick_winner_c;
                        timer_q   <= '0;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (!bus.TX_STATUS) begin
                        timer_q <= '0;
                        state_q <= ST_BUSY;
                    end else begin
                        timer_q <= timer_inc_c;
                        if (timer_q >= TMR_W'(ACK_TIMEOUT - 1)) begin
                            err_q   <= 1'b1;
                            last_q  <= owner_q;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.TX_STATUS) begin
                        done_q  <= NREQ'(1) << owner_q;
                        last_q  <= owner_q;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_inc_c;
                        if (timer_q >= TMR_W'(TIMEOUT - 1)) begin
                            err_q   <= 1'b1;
                            last_q  <= owner_q;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.GNT     = gnt_q;
    assign bus.DONE    = done_q;
    assign bus.ERR     = err_q;
    assign bus.TX_EN   = tx_en_q;
    assign bus.TX_DATA = tx_data_q;
    assign bus.OWNER   = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a grant table plus hand-written
// timeout, reset and data-hold sequences.
module tb_uart_tx_arbiter;

    logic baud_clk;
    logic reset;

    uart_tx_arbiter_if #(.NREQ(4), .DATA_W(8)) bus ();

    uart_tx_arbiter #(
        .NREQ(4), .DATA_W(8), .ACK_TIMEOUT(4), .TIMEOUT(200)
    ) dut (
        .baud_clk (baud_clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic [7:0]  data;
        int unsigned frame;
    } vec_t;

    vec_t tbl [12];

    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask

    task automatic chk(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got 0x%0h, want 0x%0h", tag, what, act, exp);
        end
    endtask

    // Present a request and check the grant one cycle later; REQ is then dropped.
    task automatic grant(input string tag, input logic [3:0] req, input logic [3:0] gnt,
                         input logic [1:0] owner, input logic [7:0] data);
        bus.REQ = req;
        tick();
        chk(tag, "gnt",     32'(bus.GNT),     32'(gnt));
        chk(tag, "tx_en",   32'(bus.TX_EN),   32'd1);
        chk(tag, "owner",   32'(bus.OWNER),   32'(owner));
        chk(tag, "tx_data", 32'(bus.TX_DATA), 32'(data));
        bus.REQ = '0;
    endtask

    // Transmitter model: ack, stay busy len cycles, then finish the byte.
    task automatic run_frame(input string tag, input int unsigned len,
                             input logic [3:0] done, input logic [7:0] data);
        int unsigned bad = 0;
        tick();
        chk(tag, "pulse_low", 32'({bus.GNT, bus.TX_EN}), 32'd0);
        bus.TX_STATUS = 1'b0;
        tick();
        repeat (len) begin
            tick();
            if (bus.DONE != 4'd0 || bus.ERR || bus.GNT != 4'd0 || bus.TX_DATA != data) bad++;
        end
        chk(tag, "busy_quiet", 32'(bad), 32'd0);
        bus.TX_STATUS = 1'b1;
        tick();
        chk(tag, "done",    32'(bus.DONE),    32'(done));
        chk(tag, "no_err",  32'(bus.ERR),     32'd0);
        chk(tag, "tx_data", 32'(bus.TX_DATA), 32'(data));
        tick();
        chk(tag, "done_once", 32'(bus.DONE), 32'd0);
    endtask

    initial begin
        int unsigned cnt;

        // R3=D3, R2=A5, R1=5C, R0=11; rotation starts after requester 3.
        tbl[0]  = '{4'b1111, 4'b0001, 2'd0, 8'h11, 160};
        tbl[1]  = '{4'b1111, 4'b0010, 2'd1, 8'h5C, 160};
        tbl[2]  = '{4'b1111, 4'b0100, 2'd2, 8'hA5, 160};
        tbl[3]  = '{4'b1111, 4'b1000, 2'd3, 8'hD3, 160};
        tbl[4]  = '{4'b1111, 4'b0001, 2'd0, 8'h11, 160};
        tbl[5]  = '{4'b0100, 4'b0100, 2'd2, 8'hA5, 20};
        tbl[6]  = '{4'b1001, 4'b1000, 2'd3, 8'hD3, 20};
        tbl[7]  = '{4'b1001, 4'b0001, 2'd0, 8'h11, 20};
        tbl[8]  = '{4'b0010, 4'b0010, 2'd1, 8'h5C, 1};
        tbl[9]  = '{4'b0011, 4'b0001, 2'd0, 8'h11, 0};
        tbl[10] = '{4'b1100, 4'b0100, 2'd2, 8'hA5, 5};
        tbl[11] = '{4'b1000, 4'b1000, 2'd3, 8'hD3, 3};

        reset         = 1'b1;
        bus.REQ       = '0;
        bus.REQ_DATA  = {8'hD3, 8'hA5, 8'h5C, 8'h11};
        bus.TX_STATUS = 1'b1;
        tick();
        tick();
        chk("reset", "gnt",     32'(bus.GNT),     32'd0);
        chk("reset", "done",    32'(bus.DONE),    32'd0);
        chk("reset", "err",     32'(bus.ERR),     32'd0);
        chk("reset", "tx_en",   32'(bus.TX_EN),   32'd0);
        chk("reset", "tx_data", 32'(bus.TX_DATA), 32'd0);
        chk("reset", "owner",   32'(bus.OWNER),   32'd3);
        #3 reset = 1'b0;

        // Single requester, full 160-cycle frame.
        tick();
        grant("single", 4'b0100, 4'b0100, 2'd2, 8'hA5);
        run_frame("single", 160, 4'b0100, 8'hA5);

        // Fresh reset so the table starts from requester 0.
        #3 reset = 1'b1;
        #1 chk("rereset", "owner", 32'(bus.OWNER), 32'd3);
        #2 reset = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            grant($sformatf("tbl%0d", i), tbl[i].req, tbl[i].gnt, tbl[i].owner, tbl[i].data);
            run_frame($sformatf("tbl%0d", i), tbl[i].frame, tbl[i].gnt, tbl[i].data);
        end

        // Transmitter never acks: ERR four cycles after START entry, no DONE.
        grant("ack_to", 4'b0010, 4'b0010, 2'd1, 8'h5C);
        cnt = 0;
        repeat (3) begin
            tick();
            if (bus.ERR || bus.DONE != 4'd0) cnt++;
        end
        chk("ack_to", "early", 32'(cnt), 32'd0);
        tick();
        chk("ack_to", "err",  32'(bus.ERR),  32'd1);
        chk("ack_to", "done", 32'(bus.DONE), 32'd0);
        grant("ack_to_next", 4'b0110, 4'b0100, 2'd2, 8'hA5);
        chk("ack_to_next", "err_once", 32'(bus.ERR), 32'd0);
        run_frame("ack_to_next", 2, 4'b0100, 8'hA5);

        // Transmitter stuck busy: ERR after 200 BUSY cycles, no grant until idle.
        grant("busy_to", 4'b0001, 4'b0001, 2'd0, 8'h11);
        tick();
        bus.TX_STATUS = 1'b0;
        tick();
        cnt = 0;
        repeat (199) begin
            tick();
            if (bus.ERR || bus.DONE != 4'd0) cnt++;
        end
        chk("busy_to", "early", 32'(cnt), 32'd0);
        tick();
        chk("busy_to", "err",  32'(bus.ERR),  32'd1);
        chk("busy_to", "done", 32'(bus.DONE), 32'd0);
        bus.REQ = 4'b0001;
        cnt = 0;
        repeat (49) begin
            tick();
            if (bus.GNT != 4'd0 || bus.TX_EN || bus.ERR) cnt++;
        end
        chk("busy_to", "held_off", 32'(cnt), 32'd0);
        bus.TX_STATUS = 1'b1;
        grant("busy_to_next", 4'b0001, 4'b0001, 2'd0, 8'h11);

        // REQ_DATA changes after GNT must not reach TX_DATA.
        bus.REQ_DATA[7:0] = 8'h22;
        run_frame("hold", 30, 4'b0001, 8'h11);
        grant("resample", 4'b0001, 4'b0001, 2'd0, 8'h22);
        bus.REQ_DATA[7:0] = 8'h11;
        run_frame("resample", 0, 4'b0001, 8'h22);

        // Reset during BUSY of requester 3.
        grant("midrst", 4'b1000, 4'b1000, 2'd3, 8'hD3);
        tick();
        bus.TX_STATUS = 1'b0;
        tick();
        repeat (10) tick();
        #3 reset = 1'b1;
        #1;
        chk("midrst", "gnt",     32'(bus.GNT),     32'd0);
        chk("midrst", "done",    32'(bus.DONE),    32'd0);
        chk("midrst", "err",     32'(bus.ERR),     32'd0);
        chk("midrst", "tx_en",   32'(bus.TX_EN),   32'd0);
        chk("midrst", "tx_data", 32'(bus.TX_DATA), 32'd0);
        chk("midrst", "owner",   32'(bus.OWNER),   32'd3);
        bus.REQ = 4'b1001;
        @(posedge baud_clk);
        #2 reset = 1'b0;
        cnt = 0;
        repeat (3) begin
            tick();
            if (bus.GNT != 4'd0 || bus.DONE != 4'd0 || bus.ERR) cnt++;
        end
        chk("midrst", "quiet", 32'(cnt), 32'd0);
        bus.TX_STATUS = 1'b1;
        grant("midrst_next", 4'b1001, 4'b0001, 2'd0, 8'h11);
        chk("midrst_next", "no_done", 32'(bus.DONE), 32'd0);
        run_frame("midrst_next", 0, 4'b0001, 8'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
